// File: rtl/vga_edge_reader.sv
// ---------------------------------------------------------------------------
// vga_edge_reader
//   Display-side reader for the Sobel edge-magnitude frame held in SDRAM.
//   Generates VGA raster timing, pops one 16-bit pixel word per visible pixel
//   from the SDRAM read-port FIFO (normal mode: data valid the cycle after
//   rd_req), and maps the 12-bit magnitude to 10-bit grey on R, G and B.
//   A FIFO underflow blanks the rest of the frame, discards stale words and
//   realigns the reader on the next frame boundary.
//
// Ports
//   clk           pixel clock
//   rst_n         asynchronous active-low reset
//   rd_data[15:0] FIFO read data; [11:0] magnitude 0..2048, [15:12] unused
//   rd_empty      FIFO empty
//   rd_req        FIFO pop request (combinational)
//   frame_sync    1-cycle pulse when h_cnt = v_cnt = 0; SDRAM side restarts
//                 its frame address on it
//   oVGA_R/G/B    10-bit grey pixel colour
//   oVGA_HS       hsync, active low
//   oVGA_VS       vsync, active low
//   oVGA_BLANK_N  high in the visible region
//   underflow     sticky underflow flag, cleared only by reset
//   dbg_state     current FSM state (0 ARM, 1 RUN, 2 DRAIN)
//
// FIFO handshake: a word is popped in every cycle where rd_req=1, and rd_req
// is only ever raised while rd_empty=0. The popped word is on rd_data in the
// following cycle, which is exactly when the registered sync/blank outputs
// for the pixel that requested it are presented.
// ---------------------------------------------------------------------------
module vga_edge_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] rd_data,
   input  logic        rd_empty,
   output logic        rd_req,
   output logic        frame_sync,
   output logic [9:0]  oVGA_R,
   output logic [9:0]  oVGA_G,
   output logic [9:0]  oVGA_B,
   output logic        oVGA_HS,
   output logic        oVGA_VS,
   output logic        oVGA_BLANK_N,
   output logic        underflow,
   output logic [1:0]  dbg_state
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_LO  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_HI  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_LO  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_HI  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic [1:0] {
      ST_ARM   = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          underflow_q, underflow_d;
   logic          pop_vld_q, pop_vld_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          blank_n_q, blank_n_d;
   logic          frame_sync_q, frame_sync_d;

   logic          active;
   logic          frame_end;
   logic          hs_raw;
   logic          vs_raw;
   logic [11:0]   mag;
   logic [9:0]    grey;
   logic [9:0]    rgb;
   logic          unused_hi;

   // ---------------- raster decode ----------------
   assign active    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
   assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
   assign hs_raw    = !((h_cnt_q >= H_SYNC_LO) && (h_cnt_q <= H_SYNC_HI));
   assign vs_raw    = !((v_cnt_q >= V_SYNC_LO) && (v_cnt_q <= V_SYNC_HI));

   always_comb begin
      h_cnt_d = h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
      end
   end

   // Sync/blank/frame_sync are delayed one cycle so they line up with the
   // word that arrives the cycle after its pop.
   always_comb begin
      hs_d         = hs_raw;
      vs_d         = vs_raw;
      blank_n_d    = active;
      frame_sync_d = frame_end;
   end

   // ---------------- reader FSM ----------------
   always_comb begin
      state_d     = state_q;
      rd_req      = 1'b0;
      underflow_d = underflow_q;
      pop_vld_d   = 1'b0;
      case (state_q)
         ST_ARM: begin
            // Start reading only on a frame boundary with data already waiting.
            if (frame_end && !rd_empty) state_d = ST_RUN;
         end
         ST_RUN: begin
            rd_req    = active && !rd_empty;
            pop_vld_d = rd_req;
            if (active && rd_empty) begin
               underflow_d = 1'b1;
               state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Words popped here belong to a broken frame; they are thrown away.
            rd_req = !rd_empty;
            if (frame_end) state_d = ST_ARM;
         end
         default: state_d = ST_ARM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ARM;
         h_cnt_q      <= '0;
         v_cnt_q      <= '0;
         underflow_q  <= 1'b0;
         pop_vld_q    <= 1'b0;
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
         blank_n_q    <= 1'b0;
         frame_sync_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         underflow_q  <= underflow_d;
         pop_vld_q    <= pop_vld_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
         blank_n_q    <= blank_n_d;
         frame_sync_q <= frame_sync_d;
      end
   end

   // ---------------- grey map ----------------
   // Magnitude saturates at 2047 and above; below that it is halved so the
   // 0..2046 range fills the 10-bit DAC. Bits [15:12] carry no pixel data.
   assign mag       = rd_data[11:0];
   assign grey      = (mag >= 12'd2047) ? 10'd1023 : mag[10:1];
   assign rgb       = pop_vld_q ? grey : 10'd0;
   assign unused_hi = ^rd_data[15:12];

   assign oVGA_R       = rgb;
   assign oVGA_G       = rgb;
   assign oVGA_B       = rgb;
   assign oVGA_HS      = hs_q;
   assign oVGA_VS      = vs_q;
   assign oVGA_BLANK_N = blank_n_q;
   assign frame_sync   = frame_sync_q;
   assign underflow    = underflow_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_vga_edge_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_edge_reader
//   Bench for vga_edge_reader using a reduced raster (15 x 8 clocks, 8 x 4
//   visible) so whole frames run in a few hundred cycles. A per-cycle reference
//   model checks every output; directed checks cover reset values, frame_sync
//   position, pop counts, sync widths, the grey-map table, underflow/drain and
//   resets (power-on, mid-frame, empty FIFO).
// ---------------------------------------------------------------------------
module tb_vga_edge_reader;

   localparam int HA  = 8;
   localparam int HFP = 2;
   localparam int HSY = 3;
   localparam int HBP = 2;
   localparam int VA  = 4;
   localparam int VFP = 1;
   localparam int VSY = 2;
   localparam int VBP = 1;
   localparam int HT  = HA + HFP + HSY + HBP;   // 15
   localparam int VT  = VA + VFP + VSY + VBP;   // 8
   localparam int FT  = HT * VT;                // 120
   localparam int NT  = 10;

   // ---------------- clock / reset / DUT ----------------
   logic        clk;
   logic        rst_n;
   logic [15:0] rd_data;
   logic        rd_empty;
   logic        rd_req;
   logic        frame_sync;
   logic [9:0]  oVGA_R, oVGA_G, oVGA_B;
   logic        oVGA_HS, oVGA_VS, oVGA_BLANK_N;
   logic        underflow;
   logic [1:0]  dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_edge_reader #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rd_data      (rd_data),
      .rd_empty     (rd_empty),
      .rd_req       (rd_req),
      .frame_sync   (frame_sync),
      .oVGA_R       (oVGA_R),
      .oVGA_G       (oVGA_G),
      .oVGA_B       (oVGA_B),
      .oVGA_HS      (oVGA_HS),
      .oVGA_VS      (oVGA_VS),
      .oVGA_BLANK_N (oVGA_BLANK_N),
      .underflow    (underflow),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // ---------------- reference model state ----------------
   int          mh, mv, ms;          // counters and state of the current cycle
   bit          m_uf;
   bit          p_hs, p_vs, p_bl, p_fs, p_pop;
   bit          last_req;
   int          mism, first_bad, cyc_n;
   logic [15:0] src_q[$];
   logic [15:0] filler;

   int obs_req, obs_fs, obs_hs, obs_vs, obs_bl, obs_uf, obs_state;
   int obs_r, obs_g, obs_b;

   function automatic logic [9:0] grey_ref(input logic [15:0] w);
      int m;
      m = int'(w & 16'h0FFF);
      if (m > 2046) return 10'd1023;
      return 10'(m / 2);
   endfunction

   task automatic model_reset();
      mh = 0; mv = 0; ms = 0; m_uf = 1'b0;
      p_hs = 1'b1; p_vs = 1'b1; p_bl = 1'b0; p_fs = 1'b0; p_pop = 1'b0;
      last_req = 1'b0;
   endtask

   task automatic model_check(input string tag);
      check($sformatf("model_%s(first_bad_cycle=%0d)", tag, first_bad), mism, 0);
      mism = 0;
      first_bad = -1;
   endtask

   // Called at posedge+1: drive inputs, sample at +3, advance model, end at next posedge+1.
   task automatic cyc(input bit emp);
      bit         act, fe, exp_req;
      logic [9:0] exp_rgb;
      if (last_req) begin
         if (src_q.size() > 0) rd_data = src_q.pop_front();
         else begin
            rd_data = filler;
            filler  = filler + 16'd37;
         end
      end
      rd_empty = emp;
      #2;
      act = (mh < HA) && (mv < VA);
      fe  = (mh == HT - 1) && (mv == VT - 1);
      case (ms)
         0:       exp_req = 1'b0;
         1:       exp_req = act && !emp;
         default: exp_req = !emp;
      endcase
      exp_rgb = p_pop ? grey_ref(rd_data) : 10'd0;
      if (rd_req !== exp_req || frame_sync !== p_fs || oVGA_HS !== p_hs ||
          oVGA_VS !== p_vs || oVGA_BLANK_N !== p_bl || oVGA_R !== exp_rgb ||
          oVGA_G !== exp_rgb || oVGA_B !== exp_rgb || underflow !== m_uf ||
          dbg_state !== 2'(ms)) begin
         if (mism == 0) first_bad = cyc_n;
         mism++;
      end
      obs_req = int'(rd_req);   obs_fs = int'(frame_sync);
      obs_hs  = int'(oVGA_HS);  obs_vs = int'(oVGA_VS);
      obs_bl  = int'(oVGA_BLANK_N);
      obs_uf  = int'(underflow); obs_state = int'(dbg_state);
      obs_r   = int'(oVGA_R);   obs_g = int'(oVGA_G); obs_b = int'(oVGA_B);
      // advance model
      p_hs  = !((mh >= HA + HFP) && (mh < HA + HFP + HSY));
      p_vs  = !((mv >= VA + VFP) && (mv < VA + VFP + VSY));
      p_bl  = act;
      p_fs  = fe;
      p_pop = (ms == 1) && exp_req;
      case (ms)
         0: if (fe && !emp) ms = 1;
         1: if (act && emp) begin ms = 2; m_uf = 1'b1; end
         default: if (fe) ms = 0;
      endcase
      if (mh == HT - 1) begin
         mh = 0;
         mv = (mv == VT - 1) ? 0 : mv + 1;
      end else mh++;
      last_req = rd_req;
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_rd_req"},     int'(rd_req),       0);
      check({tag, "_frame_sync"}, int'(frame_sync),   0);
      check({tag, "_r"},          int'(oVGA_R),       0);
      check({tag, "_g"},          int'(oVGA_G),       0);
      check({tag, "_b"},          int'(oVGA_B),       0);
      check({tag, "_hs"},         int'(oVGA_HS),      1);
      check({tag, "_vs"},         int'(oVGA_VS),      1);
      check({tag, "_blank_n"},    int'(oVGA_BLANK_N), 0);
      check({tag, "_underflow"},  int'(underflow),    0);
      check({tag, "_state"},      int'(dbg_state),    0);
   endtask

   // ---------------- grey-map vector table ----------------
   typedef struct {
      logic [15:0] word;
      int          exp;
   } vec_t;

   vec_t tbl[NT];
   int   got_r[NT], got_g[NT], got_b[NT];

   initial begin
      int cap_idx, pops, hs_lo, vs_lo, bl_hi, first_fs, st_at, bad, reqs, nz, fs_n, fs1, fs2;
      bit prev_pop, e;

      // word -> expected grey: [11:0] is the magnitude, upper nibble ignored
      tbl[0] = '{16'd0,    0};
      tbl[1] = '{16'd1,    0};
      tbl[2] = '{16'd2,    1};
      tbl[3] = '{16'd1024, 512};
      tbl[4] = '{16'd2046, 1023};
      tbl[5] = '{16'd2047, 1023};
      tbl[6] = '{16'd2048, 1023};
      tbl[7] = '{16'hF800, 1023};   // magnitude field 0x800 = 2048
      tbl[8] = '{16'h73FF, 511};    // magnitude 1023, upper bits ignored
      tbl[9] = '{16'h0FFF, 1023};   // out-of-range magnitude saturates
      for (int i = 0; i < NT; i++) begin
         got_r[i] = -1; got_g[i] = -1; got_b[i] = -1;
         src_q.push_back(tbl[i].word);
      end

      mism = 0; first_bad = -1; cyc_n = 0; filler = 16'h0155;
      rst_n = 1'b0; rd_empty = 1'b1; rd_data = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      reset_checks("por");
      rst_n = 1'b1;
      model_reset();

      // ---- full FIFO: first frame_sync, RUN entry, pops, timing, data map ----
      cap_idx = 0; pops = 0; hs_lo = 0; vs_lo = 0; bl_hi = 0;
      first_fs = -1; st_at = -1; prev_pop = 1'b0;
      for (int c = 0; c < 2 * FT; c++) begin
         cyc(1'b0);
         if (obs_fs == 1 && first_fs < 0) first_fs = c;
         if (c == FT) st_at = obs_state;
         if (prev_pop && cap_idx < NT) begin
            got_r[cap_idx] = obs_r; got_g[cap_idx] = obs_g; got_b[cap_idx] = obs_b;
            cap_idx++;
         end
         prev_pop = (obs_req == 1);
         if (c >= FT) begin
            pops  += obs_req;
            hs_lo += (obs_hs == 0) ? 1 : 0;
            vs_lo += (obs_vs == 0) ? 1 : 0;
            bl_hi += obs_bl;
         end
      end
      check("first_frame_sync_cycle", first_fs, FT);
      check("state_run_at_frame2",    st_at,    1);
      check("pops_per_frame",         pops,     HA * VA);
      check("hs_low_per_frame",       hs_lo,    HSY * VT);
      check("vs_low_per_frame",       vs_lo,    VSY * HT);
      check("blank_n_high_per_frame", bl_hi,    HA * VA);
      check("no_underflow_full_fifo", obs_uf,   0);
      for (int i = 0; i < NT; i++) begin
         check($sformatf("grey_r[%0d]", i), got_r[i], tbl[i].exp);
         check($sformatf("grey_g[%0d]", i), got_g[i], tbl[i].exp);
         check($sformatf("grey_b[%0d]", i), got_b[i], tbl[i].exp);
      end
      model_check("full_fifo");

      // ---- underflow at (h=5, v=2), drain with random empties, realign ----
      bad = 0; reqs = 0;
      for (int c = 0; c < 2 * FT + 2 * HT + 6; c++) begin
         if (c == 2 * HT + 5) e = 1'b1;
         else if (c > 2 * HT + 5 && c < FT) e = 1'($urandom_range(0, 1));
         else e = 1'b0;
         cyc(e);
         if (c == 2 * HT + 5 + 1) begin
            check("underflow_pixel_rgb", obs_r, 0);
            check("underflow_set",       obs_uf, 1);
            check("state_drain",         obs_state, 2);
         end
         if (c > 2 * HT + 5 && c < FT && obs_req != int'(!e)) bad++;
         if (c == FT) check("state_arm_after_drain", obs_state, 0);
         if (c >= FT && c < 2 * FT) reqs += obs_req;
         if (c == 2 * FT) begin
            check("state_run_after_realign", obs_state, 1);
            check("underflow_sticky",        obs_uf,    1);
         end
      end
      check("drain_req_tracks_not_empty", bad,  0);
      check("no_req_while_armed",         reqs, 0);
      model_check("underflow");

      // ---- asynchronous reset at (h=6, v=2) while reading ----
      rd_empty = 1'b0;
      #1;
      check("pre_reset_rd_req", int'(rd_req), 1);
      rst_n = 1'b0;
      #1;
      reset_checks("mid");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      reqs = 0; st_at = -1;
      for (int c = 0; c <= FT; c++) begin
         cyc(1'b0);
         if (c < FT) reqs += obs_req;
         else begin
            st_at = obs_state;
            check("first_req_after_rearm", obs_req, 1);
         end
      end
      check("no_req_first_frame_after_reset", reqs,  0);
      check("state_run_after_reset_frame",    st_at, 1);
      model_check("mid_reset");

      // ---- FIFO empty from reset: stays ARM, syncs keep running ----
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      reqs = 0; nz = 0; bad = 0; fs_n = 0; fs1 = -1; fs2 = -1; hs_lo = 0;
      for (int c = 0; c <= 2 * FT; c++) begin
         cyc(1'b1);
         reqs += obs_req;
         if (obs_r != 0 || obs_g != 0 || obs_b != 0) nz++;
         if (obs_state != 0) bad++;
         if (c >= 1 && c <= FT && obs_hs == 0) hs_lo++;
         if (obs_fs == 1) begin
            fs_n++;
            if (fs1 < 0) fs1 = c; else if (fs2 < 0) fs2 = c;
         end
      end
      check("empty_no_req",        reqs,  0);
      check("empty_rgb_zero",      nz,    0);
      check("empty_stays_arm",     bad,   0);
      check("empty_frame_syncs",   fs_n,  2);
      check("empty_fs1_cycle",     fs1,   FT);
      check("empty_fs2_cycle",     fs2,   2 * FT);
      check("empty_hs_low_frame",  hs_lo, HSY * VT);
      check("empty_no_underflow",  obs_uf, 0);
      model_check("empty_fifo");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
